key_event: RTL and testbench
============================

# key_event

Converts the two debounced button levels (I0, I1) into one-cycle game events: press, release and hold-repeat. It sits directly downstream of the button debouncer, in the same clock domain, and feeds the tank control logic. A tap produces exactly one press pulse. A held button produces a long-press repeat stream at a fixed rate until it is released.

## Interface
- LONG_CNT, default 50: cycles from the press pulse to the first repeat pulse; legal range 2 to 2^CW.
- REPEAT_CNT, default 10: cycles between successive repeat pulses; legal range 1 to 2^CW.
- CW, default 16: width of the per-channel cycle counter.

- clk  in  1  system clock; everything is sampled on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- I0  in  1  debounced level, channel 0; 1 = pressed; already synchronous to clk.
- I1  in  1  debounced level, channel 1; same as I0.
- press0, press1  out  1  one-cycle pulse on press.
- release0, release1  out  1  one-cycle pulse on release.
- repeat0, repeat1  out  1  one-cycle pulse for each hold-repeat tick.
- held0, held1  out  1  level; high while the channel is in state REPEAT.

## Operation
- The two channels are identical and fully independent; there is no shared state. Channel i has a 2-bit state, a CW-bit counter cnt, and registered outputs.
- Every output is a registered flop. No combinational path from I to any output.
- Pulse outputs (press, release, repeat) default to 0 on every edge unless a rule below sets them.
- States: IDLE, PRESS, REPEAT.
- IDLE:
  - I=1: go to PRESS, cnt<=0, press<=1.
  - I=0: stay in IDLE.
- PRESS:
  - I=0: go to IDLE, release<=1, cnt<=0.
  - Else if cnt==LONG_CNT-1: go to REPEAT, cnt<=0, repeat<=1, held<=1.
  - Else: cnt<=cnt+1.
- REPEAT:
  - I=0: go to IDLE, release<=1, held<=0, cnt<=0.
  - Else if cnt==REPEAT_CNT-1: repeat<=1, cnt<=0.
  - Else: cnt<=cnt+1.
- Release has priority over the threshold. If I=0 on the same edge cnt reaches its limit, only release fires; no repeat.
- cnt never wraps. It is cleared at each threshold, so it never exceeds max(LONG_CNT, REPEAT_CNT)-1.
- With REPEAT_CNT=1, repeat is high on every cycle while held and I=1.
- Press, release and repeat are mutually exclusive within a channel on any cycle.
- Unused state encoding: go to IDLE with cnt<=0 and all outputs 0.

## Timing
- Reset (rst_n=0), asynchronous and immediate:
  - State IDLE, cnt 0.
  - All 8 outputs are 0. Any in-flight pulse is truncated.
- Reset release with I already 1: the first clock edge after rst_n rises takes IDLE->PRESS, and press pulses. A button held through reset yields a fresh press.
- Press latency: I sampled high at edge k gives press high from edge k to edge k+1 (one cycle).
- First repeat pulse and held rising: edge k+LONG_CNT, if I stays high at every edge k+1..k+LONG_CNT.
- Subsequent repeat pulses: edges k+LONG_CNT+n*REPEAT_CNT, for n>=1.
- Release latency: I sampled low at edge m gives release high for one cycle from edge m. held falls at edge m.
- Minimum event spacing:
  - I high for a single sampled edge: press at edge k, release at edge k+1.
  - A new press may follow a release on the very next edge.
- Simultaneous events on channel 0 and channel 1 are allowed and are produced in the same cycle.

## Test plan
- Reset behaviour: drive rst_n=0 mid-REPEAT with I0=1 -> held0 and every pulse drop to 0 with no clock. Release rst_n with I0=1 -> press0 at the first edge; repeat0 50 edges later.
- Tap: I0 high for 5 cycles, then low -> press0 once at edge k, release0 once at edge k+5; repeat0 and held0 stay 0.
- Long hold: I1 high for 85 cycles (defaults) -> press1 at edge k; repeat1 at k+50, k+60, k+70, k+80; held1 high over edges k+50..k+85; release1 at k+85; exactly 4 repeat pulses.
- Threshold tie: I0 falls exactly at edge k+50 -> release0 pulses; repeat0 and held0 stay 0.
- Independence: I0 tap and I1 long hold, overlapping, with rising edges on the same clock -> press0 and press1 in the same cycle; channel-1 repeat timing unchanged by channel-0 activity.
- Back-to-back: I0 pattern 1,0,1 on consecutive edges -> press0, release0, press0 on three consecutive cycles.

Source files
------------

// File: rtl/key_event_if.sv
// key_event_if: bundles the two debounced button levels and the eight
// per-channel event outputs of key_event into a single port.
interface key_event_if;
  logic I0;
  logic I1;
  logic press0;
  logic press1;
  logic release0;
  logic release1;
  logic repeat0;
  logic repeat1;
  logic held0;
  logic held1;

  // Producer of the button levels and consumer of the events (control side).
  modport master (
    output I0, I1,
    input  press0, press1, release0, release1,
    input  repeat0, repeat1, held0, held1
  );

  // The key_event block itself.
  modport slave (
    input  I0, I1,
    output press0, press1, release0, release1,
    output repeat0, repeat1, held0, held1
  );
endinterface

// File: rtl/key_event.sv
// key_event: turns two debounced button levels into one-cycle press,
// release and hold-repeat pulses plus a "held" level. Both channels are
// identical, independent and fully registered.
module key_event #(
  parameter int LONG_CNT   = 50,
  parameter int REPEAT_CNT = 10,
  parameter int CW         = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  key_event_if.slave  kev
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_PRESS  = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  // Terminal counts: the counter restarts at zero on each threshold so it
  // never needs more than CW bits, even at the largest legal parameter.
  localparam logic [CW-1:0] LONG_LIM   = CW'(LONG_CNT - 1);
  localparam logic [CW-1:0] REPEAT_LIM = CW'(REPEAT_CNT - 1);

  wire  [1:0] w_in;
  logic [1:0] w_press;
  logic [1:0] w_release;
  logic [1:0] w_repeat;
  logic [1:0] w_held;

  assign w_in = {kev.I1, kev.I0};

  for (genvar g = 0; g < 2; g++) begin : g_ch
    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_press;
    logic          r_release;
    logic          r_repeat;
    logic          r_held;

    logic [1:0]    w_nstate;
    logic [CW-1:0] w_ncnt;
    logic          w_npress;
    logic          w_nrelease;
    logic          w_nrepeat;
    logic          w_nheld;

    // Next-state decode; release wins over a threshold hit on the same edge.
    always_comb begin
      w_nstate   = ST_IDLE;
      w_ncnt     = {CW{1'b0}};
      w_npress   = 1'b0;
      w_nrelease = 1'b0;
      w_nrepeat  = 1'b0;
      w_nheld    = 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_in[g]) begin
            w_nstate = ST_PRESS;
            w_npress = 1'b1;
          end else begin
            w_nstate = ST_IDLE;
          end
        end
        ST_PRESS: begin
          if (!w_in[g]) begin
            w_nstate   = ST_IDLE;
            w_nrelease = 1'b1;
          end else if (r_cnt == LONG_LIM) begin
            w_nstate  = ST_REPEAT;
            w_nrepeat = 1'b1;
            w_nheld   = 1'b1;
          end else begin
            w_nstate = ST_PRESS;
            w_ncnt   = r_cnt + CW'(1);
          end
        end
        ST_REPEAT: begin
          if (!w_in[g]) begin
            w_nstate   = ST_IDLE;
            w_nrelease = 1'b1;
          end else if (r_cnt == REPEAT_LIM) begin
            w_nstate  = ST_REPEAT;
            w_nrepeat = 1'b1;
            w_nheld   = 1'b1;
          end else begin
            w_nstate = ST_REPEAT;
            w_ncnt   = r_cnt + CW'(1);
            w_nheld  = 1'b1;
          end
        end
        default: begin
          // Unused encoding: fall back to IDLE with everything cleared.
          w_nstate = ST_IDLE;
        end
      endcase
    end

    // State, counter and output flops; reset truncates any pulse in flight.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state   <= ST_IDLE;
        r_cnt     <= {CW{1'b0}};
        r_press   <= 1'b0;
        r_release <= 1'b0;
        r_repeat  <= 1'b0;
        r_held    <= 1'b0;
      end else begin
        r_state   <= w_nstate;
        r_cnt     <= w_ncnt;
        r_press   <= w_npress;
        r_release <= w_nrelease;
        r_repeat  <= w_nrepeat;
        r_held    <= w_nheld;
      end
    end

    assign w_press[g]   = r_press;
    assign w_release[g] = r_release;
    assign w_repeat[g]  = r_repeat;
    assign w_held[g]    = r_held;
  end

  assign kev.press0   = w_press[0];
  assign kev.press1   = w_press[1];
  assign kev.release0 = w_release[0];
  assign kev.release1 = w_release[1];
  assign kev.repeat0  = w_repeat[0];
  assign kev.repeat1  = w_repeat[1];
  assign kev.held0    = w_held[0];
  assign kev.held1    = w_held[1];

endmodule

// File: tb/tb_key_event.sv
// tb_key_event: directed scenarios for key_event with default parameters.
module tb_key_event;
  localparam int LC = 50;
  localparam int RC = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  key_event_if u_if ();

  key_event #(.LONG_CNT(LC), .REPEAT_CNT(RC), .CW(16)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kev   (u_if.slave)
  );

  always #5 clk = ~clk;

  wire [3:0] w_ch0 = {u_if.press0, u_if.release0, u_if.repeat0, u_if.held0};
  wire [3:0] w_ch1 = {u_if.press1, u_if.release1, u_if.repeat1, u_if.held1};
  wire [7:0] w_all = {w_ch1, w_ch0};

  // Expected {press,release,repeat,held} after edge e for a button first
  // sampled high at edge 0 and first sampled low at edge fall.
  function automatic logic [3:0] hold_model(int e, int fall);
    logic p, r, q, h;
    p = (e == 0);
    r = (e == fall);
    h = (e >= LC) && (e < fall);
    q = h && (((e - LC) % RC) == 0);
    return {p, r, q, h};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    u_if.I0 = 1'b0;
    u_if.I1 = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    u_if.I0 = 1'b0;
    u_if.I1 = 1'b0;
    rst_n = 1'b0;
    #2;
    checks++;
    if (w_all !== 8'h00) begin
      failures++;
      $display("FAIL reset_initial outputs=%h expected=%h", w_all, 8'h00);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (w_all !== 8'h00) begin
      failures++;
      $display("FAIL reset_idle outputs=%h expected=%h", w_all, 8'h00);
    end
  endtask

  task automatic test_tap();
    int np, nr, nq, nh;
    np = 0; nr = 0; nq = 0; nh = 0;
    for (int e = 0; e <= 6; e++) begin
      u_if.I0 = (e < 5) ? 1'b1 : 1'b0;
      tick();
      np += int'(u_if.press0);
      nr += int'(u_if.release0);
      nq += int'(u_if.repeat0);
      nh += int'(u_if.held0);
      if (e == 0) begin
        checks++;
        if (u_if.press0 !== 1'b1) begin
          failures++;
          $display("FAIL tap_press_edge press0=%b expected=1", u_if.press0);
        end
      end
      if (e == 5) begin
        checks++;
        if (u_if.release0 !== 1'b1) begin
          failures++;
          $display("FAIL tap_release_edge release0=%b expected=1", u_if.release0);
        end
      end
    end
    checks++;
    if ({np, nr, nq, nh} !== {32'd1, 32'd1, 32'd0, 32'd0}) begin
      failures++;
      $display("FAIL tap_counts press=%0d release=%0d repeat=%0d held=%0d expected 1 1 0 0",
               np, nr, nq, nh);
    end
  endtask

  task automatic test_long_hold();
    int nq, bad;
    logic [3:0] exp_v;
    nq = 0; bad = 0;
    for (int e = 0; e <= 86; e++) begin
      u_if.I1 = (e < 85) ? 1'b1 : 1'b0;
      tick();
      exp_v = hold_model(e, 85);
      nq += int'(u_if.repeat1);
      checks++;
      if (w_ch1 !== exp_v) begin
        failures++;
        $display("FAIL long_hold_edge%0d ch1=%b expected=%b", e, w_ch1, exp_v);
      end
      checks++;
      if (w_ch0 !== 4'b0000) begin
        failures++;
        $display("FAIL long_hold_ch0_quiet edge%0d ch0=%b expected=0000", e, w_ch0);
      end
    end
    checks++;
    if (nq !== 4) begin
      failures++;
      $display("FAIL long_hold_repeat_count got=%0d expected=4", nq);
    end
  endtask

  task automatic test_threshold_tie();
    logic [3:0] exp_v;
    for (int e = 0; e <= 51; e++) begin
      u_if.I0 = (e < LC) ? 1'b1 : 1'b0;
      tick();
      exp_v = hold_model(e, LC);
      checks++;
      if (w_ch0 !== exp_v) begin
        failures++;
        $display("FAIL threshold_tie_edge%0d ch0=%b expected=%b", e, w_ch0, exp_v);
      end
    end
  endtask

  task automatic test_independence();
    logic [3:0] exp0, exp1;
    for (int e = 0; e <= 62; e++) begin
      u_if.I0 = (e < 3) ? 1'b1 : 1'b0;
      u_if.I1 = (e < 60) ? 1'b1 : 1'b0;
      tick();
      exp0 = hold_model(e, 3);
      exp1 = hold_model(e, 60);
      checks++;
      if ({w_ch1, w_ch0} !== {exp1, exp0}) begin
        failures++;
        $display("FAIL independence_edge%0d ch1=%b ch0=%b expected ch1=%b ch0=%b",
                 e, w_ch1, w_ch0, exp1, exp0);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] pat;
    logic [3:0] exp_v [4];
    pat = 4'b0101;  // I0 per edge, LSB first: 1,0,1,0
    exp_v[0] = 4'b1000;
    exp_v[1] = 4'b0100;
    exp_v[2] = 4'b1000;
    exp_v[3] = 4'b0100;
    for (int e = 0; e < 4; e++) begin
      u_if.I0 = pat[e];
      tick();
      checks++;
      if (w_ch0 !== exp_v[e]) begin
        failures++;
        $display("FAIL back_to_back_edge%0d ch0=%b expected=%b", e, w_ch0, exp_v[e]);
      end
    end
  endtask

  task automatic test_reset_mid_repeat();
    logic [3:0] exp_v;
    u_if.I0 = 1'b1;
    for (int e = 0; e <= 55; e++) tick();
    checks++;
    if (u_if.held0 !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_held held0=%b expected=1", u_if.held0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (w_all !== 8'h00) begin
      failures++;
      $display("FAIL async_reset_clear outputs=%h expected=%h", w_all, 8'h00);
    end
    tick();
    checks++;
    if (w_all !== 8'h00) begin
      failures++;
      $display("FAIL reset_hold outputs=%h expected=%h", w_all, 8'h00);
    end
    rst_n = 1'b1;
    for (int e = 0; e <= 52; e++) begin
      tick();
      exp_v = hold_model(e, 1000);
      checks++;
      if (w_ch0 !== exp_v) begin
        failures++;
        $display("FAIL post_reset_edge%0d ch0=%b expected=%b", e, w_ch0, exp_v);
      end
    end
  endtask

  initial begin
    u_if.I0 = 1'b0;
    u_if.I1 = 1'b0;
    test_reset();
    test_tap();
    go_idle();
    test_long_hold();
    go_idle();
    test_threshold_tie();
    go_idle();
    test_independence();
    go_idle();
    test_back_to_back();
    go_idle();
    test_reset_mid_repeat();
    go_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
